// File: rtl/data_mem_controller_pkg.sv
// Shared types for the data-memory controller slice.
//   DATA_WIDTH / ADDR_WIDTH    : default word and address widths
//   data_t                     : data word
//   data_memory_address_t      : data memory address
//   mc_state_t                 : controller FSM state
//   id_bits()                  : width of a consumer index (at least 1 bit)
package data_mem_controller_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] data_memory_address_t;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_READ_WAIT,
        MC_WRITE_WAIT,
        MC_RELAY
    } mc_state_t;

    // A single consumer still needs a 1-bit index so every vector stays non-empty.
    function automatic int unsigned id_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_controller_if.sv
// LSU-side and memory-side handshake bundle of the data-memory controller.
//   consumer_* : per-lane load/store requests and done pulses
//   mem_*      : single external data-memory port
// Modports:
//   slave  : the controller (responder to LSUs, requester to memory)
//   master : the surroundings (LSUs plus memory)
interface data_mem_controller_if #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 32
);

    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

endinterface

// File: rtl/data_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter.
//   request     : one request bit per requester
//   rr_ptr      : index that gets first priority
//   grant_valid : some request is set
//   grant_id    : first set index at or after rr_ptr, wrapping modulo NUM_REQ
module data_mem_controller_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_BITS = 2
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [ID_BITS-1:0] rr_ptr,
    output logic               grant_valid,
    output logic [ID_BITS-1:0] grant_id
);

    logic [ID_BITS-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_BITS'((32'(rr_ptr) + i) % NUM_REQ);
            if (!grant_valid && request[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/data_mem_controller.sv
// Data-memory controller: serves LSU loads/stores one at a time over a single memory port.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : consumer request/response lanes and the memory port (slave view)
// Every output is a register. After a memory handshake completes the controller parks in
// MC_RELAY until the served lane drops its valid, so a late-dropping LSU is not served twice.
module data_mem_controller
    import data_mem_controller_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = ADDR_WIDTH,
    parameter int unsigned DATA_BITS     = DATA_WIDTH
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_controller_if.slave bus
);

    localparam int unsigned ID_BITS = id_bits(NUM_CONSUMERS);

    mc_state_t          state;
    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS-1:0] grant_id;
    logic               relay_read;  // served op was a load (selects which valid to watch)

    logic               arb_valid;
    logic [ID_BITS-1:0] arb_id;
    logic [ID_BITS-1:0] next_ptr;

    data_mem_controller_rr_arbiter #(
        .NUM_REQ (NUM_CONSUMERS),
        .ID_BITS (ID_BITS)
    ) u_arbiter (
        .request     (bus.consumer_read_valid | bus.consumer_write_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    assign next_ptr = (arb_id == ID_BITS'(NUM_CONSUMERS - 1)) ? '0 : arb_id + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= MC_IDLE;
            rr_ptr                   <= '0;
            grant_id                 <= '0;
            relay_read               <= 1'b0;
            bus.mem_read_valid       <= 1'b0;
            bus.mem_read_address     <= ADDR_BITS'(0);
            bus.mem_write_valid      <= 1'b0;
            bus.mem_write_address    <= ADDR_BITS'(0);
            bus.mem_write_data       <= DATA_BITS'(0);
            bus.consumer_read_ready  <= '0;
            bus.consumer_read_data   <= '0;
            bus.consumer_write_ready <= '0;
        end else begin
            unique case (state)
                MC_IDLE: begin
                    if (arb_valid) begin
                        grant_id <= arb_id;
                        rr_ptr   <= next_ptr;
                        // A lane with both valids set gets its load first.
                        if (bus.consumer_read_valid[arb_id]) begin
                            relay_read           <= 1'b1;
                            bus.mem_read_valid   <= 1'b1;
                            bus.mem_read_address <= bus.consumer_read_address[arb_id];
                            state                <= MC_READ_WAIT;
                        end else begin
                            relay_read            <= 1'b0;
                            bus.mem_write_valid   <= 1'b1;
                            bus.mem_write_address <= bus.consumer_write_address[arb_id];
                            bus.mem_write_data    <= bus.consumer_write_data[arb_id];
                            state                 <= MC_WRITE_WAIT;
                        end
                    end
                end
                MC_READ_WAIT: begin
                    if (bus.mem_read_ready) begin
                        bus.mem_read_valid                <= 1'b0;
                        bus.consumer_read_data[grant_id]  <= bus.mem_read_data;
                        bus.consumer_read_ready[grant_id] <= 1'b1;
                        state                             <= MC_RELAY;
                    end
                end
                MC_WRITE_WAIT: begin
                    if (bus.mem_write_ready) begin
                        bus.mem_write_valid                <= 1'b0;
                        bus.consumer_write_ready[grant_id] <= 1'b1;
                        state                              <= MC_RELAY;
                    end
                end
                MC_RELAY: begin
                    bus.consumer_read_ready  <= '0;
                    bus.consumer_write_ready <= '0;
                    if (relay_read ? !bus.consumer_read_valid[grant_id]
                                   : !bus.consumer_write_valid[grant_id]) begin
                        state <= MC_IDLE;
                    end
                end
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Responder side of the LSU data-memory handshake. Accepts load and store requests from NUM_CONSUMERS LSUs, one per thread lane.
- Grants requests one at a time using round-robin arbitration, forwards each to a single external data-memory port, and returns the ready/data response to the requesting LSU.
- Sits between the per-thread LSUs of a core and the shared data memory.

Parameters:
- NUM_CONSUMERS, 4, number of LSU request ports; must be ≥1.
- ADDR_BITS, 8, data memory address width; matches data_memory_address_t.
- DATA_BITS, 32, data word width; matches data_t.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- consumer_read_valid  in  [NUM_CONSUMERS]  LSU load request, level-held.
- consumer_read_address  in  [NUM_CONSUMERS] x ADDR_BITS  load address.
- consumer_read_ready  out  [NUM_CONSUMERS]  one-cycle load-done pulse.
- consumer_read_data  out  [NUM_CONSUMERS] x DATA_BITS  load result.
- consumer_write_valid  in  [NUM_CONSUMERS]  LSU store request, level-held.
- consumer_write_address  in  [NUM_CONSUMERS] x ADDR_BITS  store address.
- consumer_write_data  in  [NUM_CONSUMERS] x DATA_BITS  store data.
- consumer_write_ready  out  [NUM_CONSUMERS]  one-cycle store-done pulse.
- mem_read_valid  out  1  memory read request.
- mem_read_address  out  ADDR_BITS  memory read address.
- mem_read_ready  in  1  memory read complete.
- mem_read_data  in  DATA_BITS  memory read data, valid while mem_read_ready=1.
- mem_write_valid  out  1  memory write request.
- mem_write_address  out  ADDR_BITS  memory write address.
- mem_write_data  out  DATA_BITS  memory write data.
- mem_write_ready  in  1  memory write complete.

Behaviour:
- All outputs are registered. Async reset drives every output to 0, state to MC_IDLE, rr_ptr to 0 and grant_id to 0.
- States:
  - MC_IDLE: scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS. The first index with read_valid or write_valid set is granted.
  - On grant: latch grant_id, set rr_ptr <= (grant_id+1) mod NUM_CONSUMERS.
    - If read_valid: mem_read_valid<=1, mem_read_address<=that address, go to MC_READ_WAIT.
    - Else: mem_write_valid<=1, load mem_write_address/mem_write_data, go to MC_WRITE_WAIT.
    - Read wins if both valids are set on one consumer. The write is served on a later grant.
  - MC_READ_WAIT: hold the memory request. When mem_read_ready=1: mem_read_valid<=0, consumer_read_data[grant_id]<=mem_read_data, consumer_read_ready[grant_id]<=1, go to MC_RELAY.
  - MC_WRITE_WAIT: when mem_write_ready=1: mem_write_valid<=0, consumer_write_ready[grant_id]<=1, go to MC_RELAY.
  - MC_RELAY: clear both consumer ready bits (exactly one-cycle pulse). Stay until the served valid of grant_id is 0, then go to MC_IDLE. This absorbs the LSU's one-cycle-late valid drop and prevents duplicate service.
- Minimum latency: grant edge → mem valid high next cycle. Memory ready at edge N → consumer ready high for cycle N+1.
- Stall: memory ready never arriving stalls the controller indefinitely. There is no timeout.
- Starvation bound: one transaction per requester per round-robin pass.
- Request values: address and data are sampled only at grant. Later changes while in WAIT are ignored.
- consumer_read_data[i] holds its value until the next read completes for consumer i.
- No request (all valids 0): remain in MC_IDLE; rr_ptr is unchanged.
- Reset mid-transaction: the memory transaction is abandoned and all valid/ready outputs are forced to 0 immediately.
- NUM_CONSUMERS=1: rr_ptr stays 0.

Decomposition:
- Shared package (common.svh): mc_state_t enum (MC_IDLE, MC_READ_WAIT, MC_WRITE_WAIT, MC_RELAY), alongside the existing data_t and data_memory_address_t.
- Sub-module rr_arbiter:
  - Combinational. Inputs: request vector, rr_ptr.
  - Outputs: grant_valid, grant_id.
  - Reused by future instruction-memory controller.

Test Plan:
- Single load: consumer 2 read_valid, addr 0x10; memory returns 0xDEADBEEF after 3 cycles. Expect:
  - mem_read_address=0x10.
  - consumer_read_ready[2] pulses exactly 1 cycle.
  - consumer_read_data[2]=0xDEADBEEF.
- Single store: consumer 0 write addr 0x20, data 0x1234; mem_write_ready after 1 cycle. Expect:
  - mem_write_address=0x20, mem_write_data=0x1234.
  - consumer_write_ready[0] pulses once.
- Contention: all 4 consumers read simultaneously with rr_ptr=0. Expect grant order 0,1,2,3, and each lane's data equals its own memory return.
- Late deassert: consumer 1 holds read_valid 3 extra cycles after ready. Expect:
  - Controller stays in MC_RELAY.
  - No second memory request and no second ready pulse.
- Read+write same lane: consumer 3 asserts both. Expect the read to complete first; the store is issued on the next grant once valid drops/reasserts.
- Reset mid-read: assert reset during MC_READ_WAIT. Expect mem_read_valid=0 and all ready bits 0 immediately (asynchronously); after release, state is MC_IDLE and rr_ptr=0.
